instr_fetch_unit: RTL

- Requester side of the instruction-memory read interface. Owns the PC, drives the word address into the instruction ROM and captures the returned word into the IF/ID pipeline register.
- Computes the next PC: sequential, branch, jump, or jump-register.
- Supports stall from hazard logic and MIPS branch-delay-slot semantics: redirects are issued from D and take effect after the slot instruction.
- Sits between the hazard/control unit and the decode stage of the 5-stage pipeline.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_npc_calc.sv | 35 +++
 rtl/instr_fetch_unit.sv | 76 +++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch definitions: next-PC select encodings, ROM map and fault predicate.
// The decoder and hazard unit drive npc_sel with these same encodings.
package instr_fetch_unit_pkg;

   typedef enum logic [1:0] {
      NpcSeq = 2'd0,
      NpcBr  = 2'd1,
      NpcJ   = 2'd2,
      NpcJr  = 2'd3
   } npc_sel_e;

   localparam logic [31:0] PcReset = 32'h0000_3000;
   localparam logic [31:0] ImBase  = 32'h0000_3000;
   localparam int unsigned ImWords = 2048;
   localparam logic [31:0] NopWord = 32'h0000_0000;
   localparam logic [31:0] ImLast  = ImBase + 32'(4 * ImWords) - 32'd4;

   function automatic logic is_fetch_fault(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < ImBase) || (pc > ImLast);
   endfunction

endpackage

// File: rtl/instr_fetch_unit_npc_calc.sv
// Combinational next-PC selection. Redirect targets are relative to pc_d (the
// instruction in D) so the delay-slot instruction in F is still captured.
module instr_fetch_unit_npc_calc
   import instr_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic [31:0] pc_d_i,
   input  logic [1:0]  npc_sel_i,
   input  logic        br_taken_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] instr_index_i,
   input  logic [31:0] jr_target_i,
   output logic [31:0] npc_o
);

   logic [31:0] seq_pc;
   logic [31:0] br_pc;
   logic [31:0] j_pc;

   assign seq_pc = pc_i + 32'd4;
   assign br_pc  = pc_d_i + 32'd4 + {{14{imm16_i[15]}}, imm16_i, 2'b00};
   assign j_pc   = {pc_d_i[31:28], instr_index_i, 2'b00};

   always_comb begin
      npc_o = seq_pc;
      unique case (npc_sel_e'(npc_sel_i))
         NpcSeq:  npc_o = seq_pc;
         NpcBr:   npc_o = br_taken_i ? br_pc : seq_pc;
         NpcJ:    npc_o = j_pc;
         NpcJr:   npc_o = jr_target_i;
         default: npc_o = seq_pc;
      endcase
   end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, addresses the combinational ROM and loads IF/ID.
// Faulting fetches inject a NOP with a fault flag; the PC keeps advancing.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
(
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic [1:0]  npc_sel_i,
   input  logic        br_taken_i,
   input  logic [15:0] imm16_i,
   input  logic [25:0] instr_index_i,
   input  logic [31:0] jr_target_i,
   output logic [12:2] im_addr_o,
   input  logic [31:0] im_dout_i,
   output logic [31:0] instr_d_o,
   output logic [31:0] pc_d_o,
   output logic [31:0] pc8_d_o,
   output logic        fetch_fault_d_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic        ifid_fault_q, ifid_fault_d;
   logic [31:0] npc;
   logic        fetch_fault;

   instr_fetch_unit_npc_calc u_npc_calc (
      .pc_i          (pc_q),
      .pc_d_i        (ifid_pc_q),
      .npc_sel_i     (npc_sel_i),
      .br_taken_i    (br_taken_i),
      .imm16_i       (imm16_i),
      .instr_index_i (instr_index_i),
      .jr_target_i   (jr_target_i),
      .npc_o         (npc)
   );

   assign fetch_fault = is_fetch_fault(pc_q);

   // A stall simply holds everything; control re-presents any redirect afterwards.
   always_comb begin
      pc_d         = pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_fault_d = ifid_fault_q;
      if (!stall_i) begin
         pc_d         = npc;
         ifid_instr_d = fetch_fault ? NopWord : im_dout_i;
         ifid_pc_d    = pc_q;
         ifid_fault_d = fetch_fault;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pc_q         <= PcReset;
         ifid_instr_q <= NopWord;
         ifid_pc_q    <= PcReset;
         ifid_fault_q <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_fault_q <= ifid_fault_d;
      end
   end

   assign im_addr_o       = pc_q[12:2];
   assign instr_d_o       = ifid_instr_q;
   assign pc_d_o          = ifid_pc_q;
   assign pc8_d_o         = ifid_pc_q + 32'd8;
   assign fetch_fault_d_o = ifid_fault_q;

endmodule
